// File: rtl/mem_arbiter.sv
// Two-to-one round-robin arbiter sharing one slow-memory port between the
// L2 instruction-side and data-side channels, one transaction per grant.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;  // 1 = data side granted last
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic i_req, d_req, d_win;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
    // D wins when it is alone, or on a tie when I was granted last.
    assign d_win = d_req & (~i_req | ~last_gnt_q);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;

        case (state_q)
            IDLE: begin
                if (d_win) begin
                    state_d    = GNT_D;
                    last_gnt_d = 1'b1;
                    wr_d       = d_write;
                    rd_d       = d_read & ~d_write;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                end else if (i_req) begin
                    state_d    = GNT_I;
                    last_gnt_d = 1'b0;
                    wr_d       = i_write;
                    rd_d       = i_read & ~i_write;
                    addr_d     = i_addr;
                    wdata_d    = i_wdata;
                end
            end
            GNT_I: begin
                mem_read  = rd_q & ~mem_ready;
                mem_write = wr_q & ~mem_ready;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                i_ready   = mem_ready;
                i_rdata   = mem_rdata;
                if (mem_ready) state_d = IDLE;
            end
            GNT_D: begin
                mem_read  = rd_q & ~mem_ready;
                mem_write = wr_q & ~mem_ready;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                d_ready   = mem_ready;
                d_rdata   = mem_rdata;
                if (mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 2 time units after each rising
// edge and outputs are checked 1 unit later, well clear of the clock edges.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    logic              clk = 1'b0;
    logic              proc_reset;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic              i_ready, d_ready, mem_read, mem_write, mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_rd"}, mem_read, 1'b0);
        chk({tag, ".mem_wr"}, mem_write, 1'b0);
        chk({tag, ".mem_addr"}, mem_addr, '0);
        chk({tag, ".mem_wdata"}, mem_wdata, '0);
        chk({tag, ".i_ready"}, i_ready, 1'b0);
        chk({tag, ".d_ready"}, d_ready, 1'b0);
        chk({tag, ".i_rdata"}, i_rdata, '0);
        chk({tag, ".d_rdata"}, d_rdata, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        proc_reset = 1'b1;
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        step();
        step();
        proc_reset = 1'b0;
        #1 chk_quiet("reset");

        // I-only read, memory answers on the fourth granted cycle
        i_read = 1; i_addr = 28'h0000123;
        #1 chk("t1.idle_rd", mem_read, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            chk("t1.mem_rd", mem_read, 1'b1);
            chk("t1.mem_addr", mem_addr, 28'h0000123);
            chk("t1.i_ready_early", i_ready, 1'b0);
        end
        step();
        mem_ready = 1; mem_rdata = {16{8'hA5}};
        #1;
        chk("t1.i_ready", i_ready, 1'b1);
        chk("t1.i_rdata", i_rdata, {16{8'hA5}});
        chk("t1.d_ready", d_ready, 1'b0);
        chk("t1.mem_rd_drop", mem_read, 1'b0);
        step();
        mem_ready = 0; mem_rdata = '0; i_read = 0;
        #1;
        chk("t1.i_ready_once", i_ready, 1'b0);
        chk("t1.idle_mem_rd", mem_read, 1'b0);

        // Simultaneous tie: last grant was I, so D wins
        i_read = 1; i_addr = 28'h40;
        d_write = 1; d_addr = 28'h80; d_wdata = {8{16'h1111}};
        step();
        #1;
        chk("t2.d_mem_wr", mem_write, 1'b1);
        chk("t2.d_mem_rd", mem_read, 1'b0);
        chk("t2.d_wdata", mem_wdata, {8{16'h1111}});
        chk("t2.d_addr", mem_addr, 28'h80);
        mem_ready = 1;
        #1;
        chk("t2.d_ready", d_ready, 1'b1);
        chk("t2.i_ready_no", i_ready, 1'b0);
        chk("t2.mem_wr_drop", mem_write, 1'b0);
        step();
        mem_ready = 0; d_write = 0;
        #1;
        chk("t2.gap_rd", mem_read, 1'b0);
        chk("t2.gap_wr", mem_write, 1'b0);
        step();
        #1;
        chk("t2.i_mem_rd", mem_read, 1'b1);
        chk("t2.i_addr", mem_addr, 28'h40);
        step();
        #1 chk("t2.i_wait", mem_read, 1'b1);
        step();
        mem_ready = 1; mem_rdata = {16{8'h5A}};
        #1;
        chk("t2.i_ready", i_ready, 1'b1);
        chk("t2.i_rdata", i_rdata, {16{8'h5A}});
        chk("t2.d_rdata0", d_rdata, '0);
        step();
        mem_ready = 0; mem_rdata = '0; i_read = 0;

        // Continuous contention: D, I, D, I, D, I
        i_read = 1; i_addr = 28'h100;
        d_read = 1; d_addr = 28'h200;
        for (int k = 0; k < 6; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            step();
            mem_ready = 1;
            #1;
            chk($sformatf("t3.addr%0d", k), mem_addr, exp_d ? 28'h200 : 28'h100);
            chk($sformatf("t3.d_ready%0d", k), d_ready, exp_d);
            chk($sformatf("t3.i_ready%0d", k), i_ready, !exp_d);
            step();
            mem_ready = 0;
            #1 chk($sformatf("t3.gap%0d", k), mem_read, 1'b0);
        end
        i_read = 0; d_read = 0;

        // Input change during grant is ignored (leaves last_gnt = I)
        i_read = 1; i_addr = 28'h10;
        step();
        #1 chk("t5.addr_first", mem_addr, 28'h10);
        step();
        i_addr = 28'h20;
        #1 chk("t5.addr_held", mem_addr, 28'h10);
        step();
        mem_ready = 1;
        #1;
        chk("t5.addr_end", mem_addr, 28'h10);
        chk("t5.i_ready", i_ready, 1'b1);
        step();
        mem_ready = 0; i_read = 0;
        #1 chk("t5.i_ready_once", i_ready, 1'b0);

        // Both read and write on D: write wins (leaves last_gnt = D)
        d_read = 1; d_write = 1; d_addr = 28'h00000FF; d_wdata = {8{16'h2222}};
        step();
        #1;
        chk("t4.mem_wr", mem_write, 1'b1);
        chk("t4.mem_rd", mem_read, 1'b0);
        chk("t4.addr", mem_addr, 28'h00000FF);
        mem_ready = 1;
        #1 chk("t4.d_ready", d_ready, 1'b1);
        step();
        mem_ready = 0; d_read = 0; d_write = 0;

        // Reset mid-transaction, then spurious mem_ready in IDLE
        i_read = 1; i_addr = 28'h33;
        step();
        #1 chk("t6.granted", mem_read, 1'b1);
        proc_reset = 1;
        step();
        proc_reset = 0; i_read = 0; mem_ready = 1; mem_rdata = {16{8'h77}};
        #1 chk_quiet("t6.after_reset");
        step();
        mem_ready = 0;
        #1 chk("t6.no_late_ready", i_ready, 1'b0);
        i_read = 1; i_addr = 28'h1;
        d_read = 1; d_addr = 28'h2;
        step();
        #1;
        chk("t6.tie_addr", mem_addr, 28'h2);
        chk("t6.tie_rd", mem_read, 1'b1);
        mem_ready = 1;
        #1;
        chk("t6.d_ready", d_ready, 1'b1);
        chk("t6.d_rdata", d_rdata, {16{8'h77}});
        chk("t6.i_ready", i_ready, 1'b0);
        step();
        mem_ready = 0; i_read = 0; d_read = 0; mem_rdata = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one arbiter that shares one slow-memory port between the L2 cache's instruction-side and data-side memory channels. It sits between the L2 cache's `memi_*`/`memd_*` outputs and the single external memory. Each grant carries exactly one read or write transaction. Round-robin fairness keeps either side from starving the other.

## Interface
- `ADDR_W`, 28, block address width (16-byte lines)
- `DATA_W`, 128, line data width

- `clk`  in  1  system clock, all state updates on rising edge
- `proc_reset`  in  1  synchronous, active-high reset
- `i_read` / `i_write`  in  1  instruction-side request (level, held until `i_ready`)
- `i_addr`  in  ADDR_W  instruction-side block address
- `i_wdata`  in  DATA_W  instruction-side write line
- `i_rdata`  out  DATA_W  read line, valid only while `i_ready`=1
- `i_ready`  out  1  one-cycle completion pulse for the instruction side
- `d_read` / `d_write` / `d_addr` / `d_wdata` / `d_rdata` / `d_ready`: the same set for the data side
- `mem_read` / `mem_write`  out  1  memory request
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write line
- `mem_rdata`  in  DATA_W  memory read line, valid while `mem_ready`
- `mem_ready`  in  1  memory completion pulse, one per transaction

## Operation
- **States:**
  - IDLE: no transaction outstanding.
  - GNT_I: instruction-side transaction outstanding.
  - GNT_D: data-side transaction outstanding.
- **Request decode:**
  - A side requests when `read|write` is 1.
  - If both `read` and `write` are 1, the write wins.
- **IDLE arbitration:**
  - Only one side requesting: that side wins.
  - Both sides requesting: the side not granted last wins.
  - `last_gnt` resets to I, so D wins the first tie after reset.
- **Grant latch (edge leaving IDLE):**
  - Latch the winner's op (read/write), address and wdata into internal registers.
  - Set `last_gnt` to the winner.
  - Move to GNT_I or GNT_D.
- **Granted state, memory side:**
  - `mem_addr` and `mem_wdata` are driven from the latched registers.
  - `mem_read` = latched read & ~`mem_ready`; `mem_write` = latched write & ~`mem_ready`.
  - The request therefore drops combinationally in the cycle `mem_ready` arrives.
- **Granted state, requester side:**
  - `x_ready` = `mem_ready` for the owner only; the non-owner's ready stays 0.
  - `x_rdata` = `mem_rdata` for the owner, 0 otherwise.
  - On `mem_ready`, return to IDLE.
- **In IDLE:** all `mem_*` outputs, both `ready` outputs and both `rdata` outputs are 0.
- **Latched values are stable:** requester input changes during a grant (address, data, deassertion) are ignored. The latched transaction always completes, and the owner still receives its `ready` pulse.
- **Spurious memory pulse:** `mem_ready` in IDLE is ignored and produces no requester `ready`.
- **Back-to-back requests:** a requester that re-asserts immediately after its `ready` (write-back followed by allocate) re-arbitrates in IDLE. If the other side is waiting, the other side wins.

## Timing
- **Reset values:** state = IDLE, `last_gnt` = I, latch registers = 0. All outputs are 0 in the cycle after reset is sampled.
- **Reset mid-transaction:** the transaction is abandoned with no `ready` pulse, and outputs are 0 from the next cycle.
- **Grant latency:**
  - Request visible in IDLE in cycle N: `mem_read`/`mem_write` is asserted in cycle N+1.
  - Minimum transaction with `mem_ready` in N+1: requester `ready` in N+1, state back to IDLE at N+2.
  - Turnaround: one IDLE cycle always separates consecutive grants, so the earliest next memory request is in N+3.
- **Fairness bound:** with both sides continuously requesting, grants strictly alternate. A waiting side is granted after at most one foreign transaction plus one IDLE cycle.
- **Ready semantics:** a requester `ready` is never 1 for more than one cycle per transaction. The two `ready` outputs are never 1 in the same cycle.

## Test plan
- **I-only read:** after reset, `i_read`=1, `i_addr`=0x0000123, memory responds with `mem_ready` 3 cycles after the request, `mem_rdata`=0xA5..A5.
  - `mem_read`=1 with `mem_addr`=0x0000123 from cycle 1 to the `mem_ready` cycle.
  - `i_ready`=1 with `i_rdata`=0xA5..A5 for exactly one cycle; `d_ready` stays 0.
- **Simultaneous tie:** `i_read` and `d_write` rise in the same cycle, `d_wdata`=0x1111..
  - First grant is D: `mem_write`=1, `mem_wdata`=0x1111...
  - After one IDLE cycle, I is granted.
  - Then `mem_read`=1, with `mem_ready` delayed 2 cycles.
- **Continuous contention:** both sides hold requests for 6 transactions. Grants must alternate D, I, D, I, D, I.
- **Both read and write asserted:** `d_read`=`d_write`=1, `d_addr`=0x00000FF. Output must be `mem_write`=1, `mem_read`=0.
- **Input change during grant:** change `i_addr` from 0x10 to 0x20 one cycle into a grant. `mem_addr` must stay 0x10, and `i_ready` must pulse once.
- **Reset mid-transaction:** assert `proc_reset` while in GNT_I, then pulse `mem_ready`.
  - No `i_ready` pulse.
  - All outputs are 0 one cycle after reset.
  - The next tie is won by D.
